// File: rtl/logic_pkg.sv
// Shared definitions for the registered bitwise logic unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_ACC  = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Stream bundle for logic_unit_pipe: operand/opcode input side and result output side.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on input, out_valid/out_ready on output.
//   slave  : the unit's view (consumes operands, produces results)
//   master : the surrounding datapath's view
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    import logic_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_parity;

    modport slave (
        input  in_valid, in_op, in_a, in_b, acc_clr, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_parity
    );

    modport master (
        output in_valid, in_op, in_a, in_b, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_parity
    );

endinterface

// File: rtl/logic_op_comb.sv
// Combinational opcode decode: result = op(a, b) or acc ^ a for the accumulate opcode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the result is used.
//   op_i     : opcode
//   a_i, b_i : operands (b_i unused for NOT and ACC)
//   acc_i    : accumulator value already adjusted for a same-cycle clear
//   result_o : WIDTH-bit result
module logic_op_comb
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_NAND: result_o = ~(a_i & b_i);
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_NOT:  result_o = ~a_i;
            OP_ACC:  result_o = acc_i ^ a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with XOR accumulator and a 2-entry result buffer.
// Latency: 1 cycle accept-to-out_valid; full throughput while out_ready stays high.
// Backpressure: in_ready = (buffer not full), from registered state only; results hold while stalled.
//   clk, rst : clock, async active-high reset
//   bus      : slave view of logic_unit_pipe_if (in_* operands, acc_clr, out_* results)
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    logic_unit_pipe_if.slave bus
);

    // Flags are stored alongside the data so they can never disagree with it.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             parity;
    } entry_t;

    logic [1:0]       count_q, count_d;
    entry_t           slot0_q, slot0_d;   // head of the buffer, drives the outputs
    entry_t           slot1_q, slot1_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    op_e              op_w;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] result;
    entry_t           new_entry;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             push;
    logic             pop;

    assign op_w    = op_e'(bus.in_op);
    // A same-cycle clear takes effect before the accumulate.
    assign acc_eff = bus.acc_clr ? '0 : acc_q;

    logic_op_comb #(
        .WIDTH (WIDTH)
    ) u_op (
        .op_i     (op_w),
        .a_i      (bus.in_a),
        .b_i      (bus.in_b),
        .acc_i    (acc_eff),
        .result_o (result)
    );

    assign new_entry.data   = result;
    assign new_entry.zero   = ~|result;
    assign new_entry.parity = ^result;

    assign in_ready_w  = (count_q != 2'd2);
    assign out_valid_w = (count_q != 2'd0);
    assign push        = bus.in_valid & in_ready_w;
    assign pop         = out_valid_w & bus.out_ready;

    // Buffer update. push&pop together is only possible with one entry held,
    // so the new result simply replaces the head.
    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push, pop})
            2'b11: begin
                slot0_d = new_entry;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = new_entry;
                end else begin
                    slot1_d = new_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            default: begin
            end
        endcase
    end

    // Accumulator only changes on an accepted ACC or a standalone clear.
    always_comb begin
        acc_d = acc_q;
        if (push && (op_w == OP_ACC)) begin
            acc_d = result;
        end else if (bus.acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_data   = slot0_q.data;
    assign bus.out_zero   = slot0_q.zero;
    assign bus.out_parity = slot0_q.parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    logic_unit_pipe_if #(.WIDTH(8))  bus8 ();
    logic_unit_pipe_if #(.WIDTH(32)) bus32 ();
    logic_unit_pipe_if #(.WIDTH(1))  bus1 ();

    logic_unit_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    logic_unit_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    logic_unit_pipe #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] data;
        logic       zero;
        logic       par;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic vld, logic [2:0] op, logic [7:0] a, logic [7:0] b,
                                logic clr, logic [7:0] data, logic zero, logic par);
        vec_t v;
        v.vld = vld; v.op = op; v.a = a; v.b = b; v.clr = clr;
        v.data = data; v.zero = zero; v.par = par;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive8(input logic vld, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic clr);
        bus8.in_valid = vld;
        bus8.in_op    = op;
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.acc_clr  = clr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        drive8(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        bus8.out_ready  = 1'b1;
        bus32.in_valid  = 1'b0; bus32.in_op = 3'd0; bus32.in_a = '0; bus32.in_b = '0;
        bus32.acc_clr   = 1'b0; bus32.out_ready = 1'b1;
        bus1.in_valid   = 1'b0; bus1.in_op = 3'd0; bus1.in_a = '0; bus1.in_b = '0;
        bus1.acc_clr    = 1'b0; bus1.out_ready = 1'b1;

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid",  {31'd0, bus8.out_valid},  32'd0);
        chk("rst_out_data",   {24'd0, bus8.out_data},   32'd0);
        chk("rst_out_zero",   {31'd0, bus8.out_zero},   32'd0);
        chk("rst_out_parity", {31'd0, bus8.out_parity}, 32'd0);
        chk("rst_in_ready",   {31'd0, bus8.in_ready},   32'd1);
        #19 rst = 1'b0;   // released between edges
        @(negedge clk);

        // ---------------- table: all ops, accumulator, clear ----------------
        tbl.push_back(mk(1, 3'd0, 8'hC5, 8'h3A, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 3'd1, 8'hC5, 8'h3A, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 3'd2, 8'hC5, 8'h3A, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 3'd3, 8'hC5, 8'h3A, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 3'd4, 8'hC5, 8'h3A, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 3'd5, 8'hC5, 8'h3A, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 3'd6, 8'hC5, 8'h3A, 0, 8'h3A, 0, 0));
        tbl.push_back(mk(1, 3'd0, 8'h01, 8'h03, 0, 8'h01, 0, 1));
        tbl.push_back(mk(1, 3'd1, 8'h01, 8'h03, 0, 8'h03, 0, 0));
        tbl.push_back(mk(1, 3'd2, 8'h01, 8'h03, 0, 8'h02, 0, 1));
        tbl.push_back(mk(1, 3'd3, 8'h01, 8'h03, 0, 8'hFC, 0, 0));
        tbl.push_back(mk(1, 3'd4, 8'h01, 8'h03, 0, 8'hFE, 0, 1));
        tbl.push_back(mk(1, 3'd5, 8'h01, 8'h03, 0, 8'hFD, 0, 1));
        tbl.push_back(mk(1, 3'd6, 8'h01, 8'h03, 0, 8'hFE, 0, 1));
        tbl.push_back(mk(1, 3'd7, 8'h0F, 8'h00, 0, 8'h0F, 0, 0));
        tbl.push_back(mk(1, 3'd7, 8'hF0, 8'h00, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 3'd7, 8'h0F, 8'h00, 0, 8'hF0, 0, 0));
        tbl.push_back(mk(1, 3'd7, 8'h81, 8'h00, 1, 8'h81, 0, 0));
        tbl.push_back(mk(1, 3'd7, 8'h01, 8'h00, 0, 8'h80, 0, 1));
        tbl.push_back(mk(0, 3'd0, 8'h00, 8'h00, 1, 8'h00, 0, 0));  // standalone clear
        tbl.push_back(mk(1, 3'd7, 8'h42, 8'h00, 0, 8'h42, 0, 0));
        tbl.push_back(mk(1, 3'd7, 8'h07, 8'hFF, 0, 8'h45, 0, 1));  // b ignored

        foreach (tbl[i]) begin
            drive8(tbl[i].vld, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].clr);
            @(posedge clk);
            @(negedge clk);
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_valid", i),  {31'd0, bus8.out_valid},  32'd1);
                chk($sformatf("tbl%0d_data", i),   {24'd0, bus8.out_data},   {24'd0, tbl[i].data});
                chk($sformatf("tbl%0d_zero", i),   {31'd0, bus8.out_zero},   {31'd0, tbl[i].zero});
                chk($sformatf("tbl%0d_parity", i), {31'd0, bus8.out_parity}, {31'd0, tbl[i].par});
                chk($sformatf("tbl%0d_in_ready", i), {31'd0, bus8.in_ready}, 32'd1);
            end else begin
                chk($sformatf("tbl%0d_idle_valid", i), {31'd0, bus8.out_valid}, 32'd0);
            end
        end
        drive8(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("tbl_drained", {31'd0, bus8.out_valid}, 32'd0);

        // ---------------- backpressure ----------------
        bus8.out_ready = 1'b0;
        drive8(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0);          // -> 30
        @(posedge clk); @(negedge clk);
        chk("bp_valid1", {31'd0, bus8.out_valid}, 32'd1);
        chk("bp_data1",  {24'd0, bus8.out_data},  32'h30);
        chk("bp_rdy1",   {31'd0, bus8.in_ready},  32'd1);
        drive8(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b0);          // -> FF
        @(posedge clk); @(negedge clk);
        chk("bp_rdy2",   {31'd0, bus8.in_ready},  32'd0);
        chk("bp_hold2",  {24'd0, bus8.out_data},  32'h30);
        drive8(1'b1, 3'd2, 8'h12, 8'h34, 1'b0);          // -> 26, stalled
        @(posedge clk); @(negedge clk);
        chk("bp_rdy3",   {31'd0, bus8.in_ready},  32'd0);
        chk("bp_hold3",  {24'd0, bus8.out_data},  32'h30);
        chk("bp_hold3z", {31'd0, bus8.out_zero},  32'd0);
        bus8.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);                   // first pop
        chk("bp_drain1", {24'd0, bus8.out_data},  32'hFF);
        chk("bp_rdy4",   {31'd0, bus8.in_ready},  32'd1);
        @(posedge clk); @(negedge clk);                   // 3rd accepted here
        chk("bp_drain2", {24'd0, bus8.out_data},  32'h26);
        chk("bp_drain2p",{31'd0, bus8.out_parity},32'd1);
        drive8(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("bp_empty",  {31'd0, bus8.out_valid}, 32'd0);

        // ---------------- steady stream ----------------
        for (int i = 0; i < 20; i++) begin
            drive8(1'b1, 3'd2, 8'(i), 8'h5A, 1'b0);
            @(posedge clk); @(negedge clk);
            chk($sformatf("st%0d_valid", i), {31'd0, bus8.out_valid}, 32'd1);
            chk($sformatf("st%0d_data", i),  {24'd0, bus8.out_data},  {24'd0, 8'(i) ^ 8'h5A});
            chk($sformatf("st%0d_rdy", i),   {31'd0, bus8.in_ready},  32'd1);
        end
        drive8(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("st_empty", {31'd0, bus8.out_valid}, 32'd0);

        // ---------------- async reset mid-transaction ----------------
        bus8.out_ready = 1'b0;
        drive8(1'b1, 3'd7, 8'h55, 8'h00, 1'b1);          // acc <= 55
        @(posedge clk); @(negedge clk);
        drive8(1'b1, 3'd6, 8'h00, 8'h00, 1'b0);          // -> FF
        @(posedge clk); @(negedge clk);
        drive8(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        chk("ar_full",   {31'd0, bus8.in_ready},  32'd0);
        chk("ar_head",   {24'd0, bus8.out_data},  32'h55);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid",  {31'd0, bus8.out_valid},  32'd0);
        chk("ar_data",   {24'd0, bus8.out_data},   32'd0);
        chk("ar_zero",   {31'd0, bus8.out_zero},   32'd0);
        chk("ar_parity", {31'd0, bus8.out_parity}, 32'd0);
        chk("ar_rdy",    {31'd0, bus8.in_ready},   32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ar_post_valid", {31'd0, bus8.out_valid}, 32'd0);
        bus8.out_ready = 1'b1;
        drive8(1'b1, 3'd7, 8'h01, 8'h00, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("ar_acc_valid", {31'd0, bus8.out_valid}, 32'd1);
        chk("ar_acc_data",  {24'd0, bus8.out_data},  32'h01);
        drive8(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

        // ---------------- WIDTH=32 and WIDTH=1 builds ----------------
        bus32.in_valid = 1'b1; bus32.in_op = 3'd2;
        bus32.in_a = 32'hFFFF0000; bus32.in_b = 32'h0000FFFF;
        bus1.in_valid = 1'b1; bus1.in_op = 3'd4; bus1.in_a = 1'b1; bus1.in_b = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("w32_data",   bus32.out_data,                   32'hFFFFFFFF);
        chk("w32_parity", {31'd0, bus32.out_parity},        32'd0);
        chk("w32_zero",   {31'd0, bus32.out_zero},          32'd0);
        chk("w1_data",    {31'd0, bus1.out_data},           32'd0);
        chk("w1_zero",    {31'd0, bus1.out_zero},           32'd1);
        bus32.in_op = 3'd1; bus32.in_a = '0; bus32.in_b = '0;
        bus1.in_op = 3'd6; bus1.in_a = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("w32_zero2",  {31'd0, bus32.out_zero},          32'd1);
        chk("w1_not",     {31'd0, bus1.out_data},           32'd1);
        chk("w1_parity",  {31'd0, bus1.out_parity},         32'd1);
        bus32.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
